// File: rtl/jesd204b_pkg.sv
// JESD204B TX data link layer: shared control characters and state encoding.
// Imported by jesd204b_dll_tx and jesd204b_scrambler32.
package jesd204b_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;  // /K/ code group sync
    localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
    localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
    localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config follows
    localparam logic [7:0] K28_7 = 8'hFC;  // /F/ frame end

    localparam logic [14:0] SCR_SEED = 15'h7FFF;

    typedef enum logic [1:0] {
        CGS  = 2'd0,
        ILAS = 2'd1,
        DATA = 2'd2
    } dll_state_e;

endpackage

// File: rtl/jesd204b_scrambler32.sv
// 32-bit parallel self-synchronous scrambler, 1 + x^14 + x^15, MSB first.
// Ports: clk, rst_n (async, active-low), en (0 reseeds), din[31:0], dout[31:0] (comb).
module jesd204b_scrambler32
    import jesd204b_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    // hist[0] is the most recent scrambled bit, hist[14] the oldest.
    logic [14:0] hist_q;
    logic [14:0] hist_d;

    always_comb begin
        logic [14:0] h;
        logic        s;
        h    = hist_q;
        s    = 1'b0;
        dout = '0;
        for (int i = 31; i >= 0; i--) begin
            s       = din[i] ^ h[13] ^ h[14];
            dout[i] = s;
            h       = {h[13:0], s};
        end
        hist_d = h;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= SCR_SEED;
        end else begin
            hist_q <= en ? hist_d : SCR_SEED;
        end
    end

endmodule

// File: rtl/jesd204b_dll_tx.sv
// JESD204B per-lane TX data link layer: CGS, ILAS, then user data with
// frame/multiframe character replacement. Optional scrambling: SCRAMBLE_EN.
// Ports: clk, rst_n (async, active-low), sync_n, tx_datain[31:0],
//   ilas_config[111:0] in; tx_ready, tx_dataout[31:0], tx_charisk[3:0],
//   lmfc_pulse out. Octet 0 sits in the MSBs; charisk bit 3 is octet 0.
module jesd204b_dll_tx
    import jesd204b_pkg::*;
#(
    parameter int FRAMES_PER_MULTI = 32,
    parameter int ILAS_MULTI       = 4,
    parameter int SYNC_FILTER      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sync_n,
    input  logic [31:0]  tx_datain,
    input  logic [111:0] ilas_config,
    output logic         tx_ready,
    output logic [31:0]  tx_dataout,
    output logic [3:0]   tx_charisk,
    output logic         lmfc_pulse
);

    localparam logic [5:0] K_LAST  = 6'(FRAMES_PER_MULTI - 1);
    localparam logic [7:0] MF_LAST = 8'(ILAS_MULTI - 1);
    localparam logic [7:0] O_LAST  = 8'(4 * FRAMES_PER_MULTI - 1);
    localparam logic [7:0] LOW_MAX = 8'(SYNC_FILTER - 1);

    // ILAS multiframe 1 needs octets 0..15 plus /A/.
    if (FRAMES_PER_MULTI < 5 || FRAMES_PER_MULTI > 32) begin : g_bad_k
        $error("jesd204b_dll_tx: FRAMES_PER_MULTI must be 5..32");
    end
    if (SYNC_FILTER < 1 || ILAS_MULTI < 1) begin : g_bad_cfg
        $error("jesd204b_dll_tx: SYNC_FILTER and ILAS_MULTI must be >= 1");
    end

    dll_state_e  state_q, state_d;
    logic [5:0]  lmfc_cnt_q, cnt_d;
    logic [7:0]  mf_q, mf_d;
    logic [7:0]  low_q, low_d;
    logic        trip;
    logic [31:0] dout_d;
    logic [3:0]  kout_d;
    logic [7:0]  oct;
    logic [7:0]  ch;
    logic        isk;
    logic [111:0] cfg_sh;

`ifdef SCRAMBLE_EN
    logic [31:0] scr_out;

    jesd204b_scrambler32 u_scr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_d == DATA),
        .din   (tx_datain),
        .dout  (scr_out)
    );
`else
    logic [7:0] prev_last_q;
`endif

    // All outputs are registered from the *_d values, so every decision
    // below is about the beat that appears after this edge (LMFC tag cnt_d).
    always_comb begin
        cnt_d   = (lmfc_cnt_q == K_LAST) ? 6'd0 : lmfc_cnt_q + 6'd1;
        trip    = !sync_n && (low_q == LOW_MAX);
        low_d   = sync_n ? 8'd0 :
                  (low_q == LOW_MAX) ? low_q : low_q + 8'd1;
        state_d = state_q;
        mf_d    = mf_q;

        unique case (state_q)
            CGS: begin
                if (sync_n && cnt_d == 6'd0) begin
                    state_d = ILAS;
                    mf_d    = 8'd0;
                end
            end
            ILAS: begin
                if (trip) begin
                    state_d = CGS;
                end else if (cnt_d == 6'd0) begin
                    if (mf_q == MF_LAST) state_d = DATA;
                    else mf_d = mf_q + 8'd1;
                end
            end
            DATA: begin
                if (trip) state_d = CGS;
            end
            default: state_d = CGS;
        endcase

        dout_d = '0;
        kout_d = '0;
        oct    = '0;
        ch     = '0;
        isk    = 1'b0;
        cfg_sh = '0;

        unique case (state_d)
            CGS: begin
                dout_d = {4{K28_5}};
                kout_d = 4'hF;
            end
            ILAS: begin
                for (int l = 0; l < 4; l++) begin
                    oct = {cnt_d, 2'(l)};
                    ch  = oct;
                    isk = 1'b0;
                    if (oct == 8'd0) begin
                        ch  = K28_0;
                        isk = 1'b1;
                    end else if (oct == O_LAST) begin
                        ch  = K28_3;
                        isk = 1'b1;
                    end else if (mf_d == 8'd1 && oct == 8'd1) begin
                        ch  = K28_4;
                        isk = 1'b1;
                    end else if (mf_d == 8'd1 && oct <= 8'd15) begin
                        cfg_sh = ilas_config << (8 * (oct - 8'd2));
                        ch     = cfg_sh[111:104];
                    end
                    dout_d[31-8*l -: 8] = ch;
                    kout_d[3-l]         = isk;
                end
            end
            DATA: begin
`ifdef SCRAMBLE_EN
                dout_d = scr_out;
                if (scr_out[7:0] == K28_7 ||
                    (scr_out[7:0] == K28_3 && cnt_d == K_LAST)) begin
                    kout_d = 4'b0001;
                end
`else
                dout_d = tx_datain;
                // tx_ready high means the previous beat was DATA, so
                // prev_last_q holds a valid frame-end octet.
                if (tx_ready && tx_datain[7:0] == prev_last_q) begin
                    dout_d[7:0] = (cnt_d == K_LAST) ? K28_3 : K28_7;
                    kout_d      = 4'b0001;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CGS;
            lmfc_cnt_q <= '0;
            mf_q       <= '0;
            low_q      <= '0;
            tx_ready   <= 1'b0;
            tx_dataout <= '0;
            tx_charisk <= '0;
            lmfc_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            lmfc_cnt_q <= cnt_d;
            mf_q       <= mf_d;
            low_q      <= low_d;
            tx_ready   <= (state_d == DATA);
            tx_dataout <= dout_d;
            tx_charisk <= kout_d;
            lmfc_pulse <= (cnt_d == 6'd0);
        end
    end

`ifndef SCRAMBLE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_last_q <= '0;
        end else if (state_d == DATA) begin
            prev_last_q <= tx_datain[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_jesd204b_dll_tx.sv
// Self-checking bench for jesd204b_dll_tx with a behavioural lane model.
// Honours SCRAMBLE_EN the same way the design does.
module tb_jesd204b_dll_tx;

    localparam int K  = 32;
    localparam int IM = 4;
    localparam int SF = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sync_n;
    logic [31:0]  tx_datain;
    logic [111:0] ilas_config;
    logic         tx_ready;
    logic [31:0]  tx_dataout;
    logic [3:0]   tx_charisk;
    logic         lmfc_pulse;

    int checks = 0;
    int errors = 0;

    // behavioural model state: phase 0=CGS 1=ILAS 2=DATA
    int         m_phase, m_cnt, m_beat, m_low;
    bit         m_pv;
    logic [7:0] m_prev;
    bit         sq[$];
    logic [31:0] exp_data;
    logic [3:0]  exp_k;
    logic        exp_ready, exp_pulse;

    jesd204b_dll_tx #(
        .FRAMES_PER_MULTI (K),
        .ILAS_MULTI       (IM),
        .SYNC_FILTER      (SF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sync_n      (sync_n),
        .tx_datain   (tx_datain),
        .ilas_config (ilas_config),
        .tx_ready    (tx_ready),
        .tx_dataout  (tx_dataout),
        .tx_charisk  (tx_charisk),
        .lmfc_pulse  (lmfc_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic seed_scr();
        sq.delete();
        for (int i = 0; i < 15; i++) sq.push_back(1'b1);
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_beat  = 0;
        m_low   = 0;
        m_pv    = 0;
        m_prev  = '0;
        seed_scr();
    endtask

    function automatic logic [31:0] rframe();
        logic [31:0] r;
        r      = $urandom;
        r[7:0] = 8'($urandom_range(0, 3));
        return r;
    endfunction

    // Expected outputs after the edge that samples (s, d).
    task automatic model_edge(input logic s, input logic [31:0] d);
        int cn, mf, b, o;
        bit trip;
        logic [7:0] v;
        logic kk, sb;
        logic [111:0] tmp;
        logic [31:0] sd;
        cn = (m_cnt + 1) % K;
        if (s) m_low = 0;
        else m_low++;
        trip = (m_low >= SF);
        case (m_phase)
            0: if (s && cn == 0) begin
                m_phase = 1;
                m_beat  = 0;
            end
            1: if (trip) m_phase = 0;
            else begin
                m_beat++;
                if (m_beat == IM * K) begin
                    m_phase = 2;
                    m_pv    = 0;
                    seed_scr();
                end
            end
            default: if (trip) m_phase = 0;
        endcase
        exp_pulse = (cn == 0);
        exp_ready = (m_phase == 2);
        exp_data  = '0;
        exp_k     = '0;
        if (m_phase == 0) begin
            exp_data = 32'hBCBCBCBC;
            exp_k    = 4'hF;
        end else if (m_phase == 1) begin
            mf = m_beat / K;
            b  = m_beat % K;
            for (int l = 0; l < 4; l++) begin
                o  = 4 * b + l;
                v  = 8'(o);
                kk = 1'b0;
                if (o == 0) begin
                    v = 8'h1C; kk = 1'b1;
                end else if (o == 4 * K - 1) begin
                    v = 8'h7C; kk = 1'b1;
                end else if (mf == 1 && o == 1) begin
                    v = 8'h9C; kk = 1'b1;
                end else if (mf == 1 && o >= 2 && o <= 15) begin
                    tmp = ilas_config >> (104 - 8 * (o - 2));
                    v   = tmp[7:0];
                end
                exp_data[31-8*l -: 8] = v;
                exp_k[3-l]            = kk;
            end
        end else begin
`ifdef SCRAMBLE_EN
            sd = '0;
            for (int i = 31; i >= 0; i--) begin
                sb    = d[i] ^ sq[$-13] ^ sq[$-14];
                sd[i] = sb;
                sq.push_back(sb);
                void'(sq.pop_front());
            end
            exp_data = sd;
            if (sd[7:0] == 8'hFC || (sd[7:0] == 8'h7C && cn == K - 1))
                exp_k = 4'b0001;
`else
            sd       = d;
            exp_data = sd;
            if (m_pv && d[7:0] == m_prev) begin
                exp_data[7:0] = (cn == K - 1) ? 8'h7C : 8'hFC;
                exp_k         = 4'b0001;
            end
            m_prev = d[7:0];
            m_pv   = 1;
`endif
        end
        m_cnt = cn;
    endtask

    task automatic tick(input logic s, input logic [31:0] d);
        sync_n    = s;
        tx_datain = d;
        model_edge(s, d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({tx_dataout, tx_charisk, tx_ready, lmfc_pulse} !== 38'd0) begin
            errors++;
            $display("FAIL reset_zero: got %h k=%b rdy=%b pls=%b, need all 0",
                     tx_dataout, tx_charisk, tx_ready, lmfc_pulse);
        end
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < K + 8; n++) begin
            tick(1'b0, $urandom);
            checks++;
            if ({tx_dataout, tx_charisk, tx_ready, lmfc_pulse} !==
                {exp_data, exp_k, exp_ready, exp_pulse}) begin
                errors++;
                $display("FAIL cgs_beat: got %h k=%b rdy=%b pls=%b, exp %h k=%b rdy=%b pls=%b",
                         tx_dataout, tx_charisk, tx_ready, lmfc_pulse,
                         exp_data, exp_k, exp_ready, exp_pulse);
            end
            checks++;
            if ({tx_dataout, tx_charisk, tx_ready} !== {32'hBCBCBCBC, 4'hF, 1'b0}) begin
                errors++;
                $display("FAIL cgs_const: got %h k=%b rdy=%b, need bcbcbcbc k=1111 rdy=0",
                         tx_dataout, tx_charisk, tx_ready);
            end
        end
    endtask

    task automatic test_ilas();
        int n;
        n = 0;
        // a brief sync_n high that never meets an LMFC boundary
        while (m_cnt != 3 && n < 2 * K) begin
            tick(1'b0, $urandom);
            n++;
        end
        for (int i = 0; i < 3; i++) tick(1'b1, $urandom);
        n = 0;
        while (m_cnt != 10 && n < 2 * K) begin
            tick(1'b0, $urandom);
            n++;
            checks++;
            if ({tx_dataout, tx_charisk, tx_ready, lmfc_pulse} !==
                {exp_data, exp_k, exp_ready, exp_pulse}) begin
                errors++;
                $display("FAIL cgs_hold: got %h k=%b rdy=%b pls=%b, exp %h k=%b rdy=%b pls=%b",
                         tx_dataout, tx_charisk, tx_ready, lmfc_pulse,
                         exp_data, exp_k, exp_ready, exp_pulse);
            end
        end
        n = 0;
        while (!(m_phase == 1 && m_beat == K + 3) && n < 3 * K) begin
            tick(1'b1, $urandom);
            n++;
            checks++;
            if ({tx_dataout, tx_charisk, tx_ready, lmfc_pulse} !==
                {exp_data, exp_k, exp_ready, exp_pulse}) begin
                errors++;
                $display("FAIL ilas_beat: got %h k=%b rdy=%b pls=%b, exp %h k=%b rdy=%b pls=%b",
                         tx_dataout, tx_charisk, tx_ready, lmfc_pulse,
                         exp_data, exp_k, exp_ready, exp_pulse);
            end
            if (m_phase == 1 && m_beat == 0) begin
                checks++;
                if ({tx_dataout, tx_charisk, lmfc_pulse} !== {32'h1C010203, 4'b1000, 1'b1}) begin
                    errors++;
                    $display("FAIL ilas_mf0_b0: got %h k=%b pls=%b, need 1c010203 k=1000 pls=1",
                             tx_dataout, tx_charisk, lmfc_pulse);
                end
            end
            if (m_phase == 1 && m_beat == K - 1) begin
                checks++;
                if ({tx_dataout, tx_charisk} !== {32'h7C7D7E7C, 4'b0001}) begin
                    errors++;
                    $display("FAIL ilas_mf0_last: got %h k=%b, need 7c7d7e7c k=0001",
                             tx_dataout, tx_charisk);
                end
            end
            if (m_phase == 1 && m_beat == K) begin
                checks++;
                if ({tx_dataout, tx_charisk} !==
                    {8'h1C, 8'h9C, ilas_config[111:96], 4'b1100}) begin
                    errors++;
                    $display("FAIL ilas_mf1_b0: got %h k=%b, need 1c9c%h k=1100",
                             tx_dataout, tx_charisk, ilas_config[111:96]);
                end
            end
        end
        checks++;
        if (n >= 3 * K) begin
            errors++;
            $display("FAIL ilas_timeout: got %0d cycles, need ILAS start within %0d",
                     n, 3 * K);
        end
    endtask

    task automatic test_data();
        int n;
        logic [31:0] r;
        n = 0;
        while (m_phase != 2 && n < IM * K + 10) begin
            r      = $urandom;
            r[7:0] = 8'h00;
            tick(1'b1, r);
            n++;
            checks++;
            if ({tx_dataout, tx_charisk, tx_ready, lmfc_pulse} !==
                {exp_data, exp_k, exp_ready, exp_pulse}) begin
                errors++;
                $display("FAIL ilas_to_data: got %h k=%b rdy=%b pls=%b, exp %h k=%b rdy=%b pls=%b",
                         tx_dataout, tx_charisk, tx_ready, lmfc_pulse,
                         exp_data, exp_k, exp_ready, exp_pulse);
            end
        end
        checks++;
        if ({tx_ready, lmfc_pulse, tx_charisk, tx_dataout[7:0]} !== {2'b11, 4'b0000, 8'h00}) begin
            errors++;
            $display("FAIL data_first: got rdy=%b pls=%b k=%b oct3=%h, need rdy=1 pls=1 k=0000 oct3=00",
                     tx_ready, lmfc_pulse, tx_charisk, tx_dataout[7:0]);
        end
        for (int i = 0; i < 3 * K; i++) begin
            tick(1'b1, rframe());
            checks++;
            if ({tx_dataout, tx_charisk, tx_ready, lmfc_pulse} !==
                {exp_data, exp_k, exp_ready, exp_pulse}) begin
                errors++;
                $display("FAIL data_rand: got %h k=%b rdy=%b pls=%b, exp %h k=%b rdy=%b pls=%b",
                         tx_dataout, tx_charisk, tx_ready, lmfc_pulse,
                         exp_data, exp_k, exp_ready, exp_pulse);
            end
        end
        while (m_cnt != 13) tick(1'b1, rframe());
        tick(1'b1, 32'h12345678);
        tick(1'b1, 32'h12345678);
        checks++;
        if ({tx_dataout, tx_charisk} !== {32'h123456FC, 4'b0001}) begin
            errors++;
            $display("FAIL repl_f: got %h k=%b, need 123456fc k=0001",
                     tx_dataout, tx_charisk);
        end
        while (m_cnt != K - 3) tick(1'b1, rframe());
        tick(1'b1, 32'h12345678);
        tick(1'b1, 32'h12345678);
        checks++;
        if ({tx_dataout, tx_charisk, lmfc_pulse} !== {32'h1234567C, 4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL repl_a: got %h k=%b pls=%b, need 1234567c k=0001 pls=0",
                     tx_dataout, tx_charisk, lmfc_pulse);
        end
    endtask

    task automatic test_scramble();
        int n;
        bit dq[$];
        logic [31:0] d, dd;
        logic rb;
        n = 0;
        while (m_phase != 2 && n < IM * K + 10) begin
            tick(1'b1, $urandom);
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL scr_entry: got rdy=%b, need 1", tx_ready);
        end
        for (int i = 0; i < 15; i++) dq.push_back(1'b1);
        d = $urandom;
        for (int i = 0; i < 3 * K; i++) begin
            d = d + 32'd1;
            tick(1'b1, d);
            checks++;
            if ({tx_dataout, tx_charisk, tx_ready, lmfc_pulse} !==
                {exp_data, exp_k, exp_ready, exp_pulse}) begin
                errors++;
                $display("FAIL scr_model: got %h k=%b rdy=%b pls=%b, exp %h k=%b rdy=%b pls=%b",
                         tx_dataout, tx_charisk, tx_ready, lmfc_pulse,
                         exp_data, exp_k, exp_ready, exp_pulse);
            end
            dd = '0;
            for (int j = 31; j >= 0; j--) begin
                rb    = tx_dataout[j];
                dd[j] = rb ^ dq[$-13] ^ dq[$-14];
                dq.push_back(rb);
                void'(dq.pop_front());
            end
            checks++;
            if (dd !== d) begin
                errors++;
                $display("FAIL descramble: got %h, need %h", dd, d);
            end
        end
    endtask

    task automatic test_resync();
        logic [31:0] r;
        int n;
        for (int step = 0; step < 12; step++) begin
            r      = $urandom;
            r[7:0] = 8'hAB;
            // 3 low, 2 high, then 4 low
            tick((step < 3 || step == 3 || step == 4) ? (step >= 3) : 1'b0, r);
            checks++;
            if ({tx_dataout, tx_charisk, tx_ready, lmfc_pulse} !==
                {exp_data, exp_k, exp_ready, exp_pulse}) begin
                errors++;
                $display("FAIL resync_seq: got %h k=%b rdy=%b pls=%b, exp %h k=%b rdy=%b pls=%b",
                         tx_dataout, tx_charisk, tx_ready, lmfc_pulse,
                         exp_data, exp_k, exp_ready, exp_pulse);
            end
            if (step == 2) begin
                checks++;
                if (tx_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL short_low: got rdy=%b, need 1", tx_ready);
                end
            end
            if (step == 8) begin
                checks++;
                if ({tx_dataout, tx_charisk, tx_ready} !== {32'hBCBCBCBC, 4'hF, 1'b0}) begin
                    errors++;
                    $display("FAIL resync_cgs: got %h k=%b rdy=%b, need bcbcbcbc k=1111 rdy=0",
                             tx_dataout, tx_charisk, tx_ready);
                end
            end
        end
        n = 0;
        while (m_phase != 2 && n < (IM + 2) * K) begin
            r      = $urandom;
            r[7:0] = 8'hAB;
            tick(1'b1, r);
            n++;
            checks++;
            if ({tx_dataout, tx_charisk, tx_ready, lmfc_pulse} !==
                {exp_data, exp_k, exp_ready, exp_pulse}) begin
                errors++;
                $display("FAIL rejoin: got %h k=%b rdy=%b pls=%b, exp %h k=%b rdy=%b pls=%b",
                         tx_dataout, tx_charisk, tx_ready, lmfc_pulse,
                         exp_data, exp_k, exp_ready, exp_pulse);
            end
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rejoin_ready: got rdy=%b, need 1", tx_ready);
        end
`ifndef SCRAMBLE_EN
        checks++;
        if ({tx_dataout[7:0], tx_charisk} !== {8'hAB, 4'b0000}) begin
            errors++;
            $display("FAIL rejoin_first: got oct3=%h k=%b, need ab k=0000",
                     tx_dataout[7:0], tx_charisk);
        end
`endif
        for (int i = 0; i < K; i++) begin
            tick(1'b1, rframe());
            checks++;
            if ({tx_dataout, tx_charisk, tx_ready, lmfc_pulse} !==
                {exp_data, exp_k, exp_ready, exp_pulse}) begin
                errors++;
                $display("FAIL back_to_back: got %h k=%b rdy=%b pls=%b, exp %h k=%b rdy=%b pls=%b",
                         tx_dataout, tx_charisk, tx_ready, lmfc_pulse,
                         exp_data, exp_k, exp_ready, exp_pulse);
            end
        end
    endtask

    task automatic test_reset_mid_ilas();
        int n;
        for (int i = 0; i < SF; i++) tick(1'b0, $urandom);
        n = 0;
        while (!(m_phase == 1 && m_beat == 40) && n < (IM + 2) * K) begin
            tick(1'b1, $urandom);
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_dataout, tx_charisk, tx_ready, lmfc_pulse} !== 38'd0) begin
            errors++;
            $display("FAIL async_reset: got %h k=%b rdy=%b pls=%b, need all 0",
                     tx_dataout, tx_charisk, tx_ready, lmfc_pulse);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        n = 0;
        while (!(m_phase == 1 && m_beat == 4) && n < 3 * K) begin
            tick(1'b1, $urandom);
            n++;
            checks++;
            if ({tx_dataout, tx_charisk, tx_ready, lmfc_pulse} !==
                {exp_data, exp_k, exp_ready, exp_pulse}) begin
                errors++;
                $display("FAIL restart: got %h k=%b rdy=%b pls=%b, exp %h k=%b rdy=%b pls=%b",
                         tx_dataout, tx_charisk, tx_ready, lmfc_pulse,
                         exp_data, exp_k, exp_ready, exp_pulse);
            end
            if (m_phase == 1 && m_beat == 0) begin
                checks++;
                if ({n, tx_dataout, tx_charisk} !== {K, 32'h1C010203, 4'b1000}) begin
                    errors++;
                    $display("FAIL restart_mf0: got cycle %0d %h k=%b, need cycle %0d 1c010203 k=1000",
                             n, tx_dataout, tx_charisk, K);
                end
            end
        end
        checks++;
        if (n >= 3 * K) begin
            errors++;
            $display("FAIL restart_timeout: got %0d cycles without ILAS", n);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        sync_n      = 1'b0;
        tx_datain   = '0;
        ilas_config = 112'({$urandom, $urandom, $urandom, $urandom});
        model_reset();
        test_reset();
        test_ilas();
`ifdef SCRAMBLE_EN
        test_scramble();
`else
        test_data();
`endif
        test_resync();
        test_reset_mid_ilas();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
